// File: rtl/parallel_tone_source.sv
// parallel_tone_source: LANES consecutive samples of a programmable sine tone per clock,
// from one phase accumulator and a shared sine ROM. Optional lane LSB dither: TONE_SOURCE_DITHER_EN.

module parallel_tone_source #(
    parameter int LANES       = 3,
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 9,
    parameter int PHASE_WIDTH = 24
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        start,
    input  logic                        stop,
    input  logic [PHASE_WIDTH-1:0]      phase_inc,
    input  logic [15:0]                 burst_len,
    output logic [LANES*DATA_WIDTH-1:0] data_out,
    output logic                        valid,
    output logic                        busy,
    output logic                        done,
    output logic [1:0]                  state_dbg
);

    localparam int DEPTH   = 1 << ADDR_WIDTH;
    localparam int QUARTER = DEPTH / 4;

    // ROM image entry i = round((2^(DATA_WIDTH-1)-1) * sin(2*pi*i/DEPTH)), built at elaboration
    // with 60-bit fixed-point Taylor series on the first quadrant and folded by symmetry.
    function automatic logic [DATA_WIDTH-1:0] sine_entry(input int idx);
        logic [127:0] x;
        logic [127:0] x2;
        logic [127:0] term;
        logic [127:0] sum;
        logic [127:0] mag;
        int           quad;
        int           rem;
        int           ang;
        quad = idx / QUARTER;
        rem  = idx % QUARTER;
        ang  = (quad % 2 == 1) ? (QUARTER - rem) : rem;
        x    = (128'h6487ED5110B4611A * 128'(ang)) >> ADDR_WIDTH;
        x2   = (x * x) >> 60;
        term = x;
        sum  = x;
        for (int n = 1; n <= 13; n++) begin
            term = ((term * x2) >> 60) / 128'((2 * n) * (2 * n + 1));
            sum  = (n % 2 == 1) ? (sum - term) : (sum + term);
        end
        mag = ((sum * ((128'd1 << (DATA_WIDTH - 1)) - 128'd1)) + (128'd1 << 59)) >> 60;
        return (quad >= 2) ? (DATA_WIDTH'(0) - mag[DATA_WIDTH-1:0]) : mag[DATA_WIDTH-1:0];
    endfunction

    logic [DATA_WIDTH-1:0] rom [DEPTH];

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rom
        localparam logic [DATA_WIDTH-1:0] ENTRY = sine_entry(gi);
        assign rom[gi] = ENTRY;
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [PHASE_WIDTH-1:0]  phase_q, phase_d;
    logic [PHASE_WIDTH-1:0]  inc_q, inc_d;
    logic [15:0]             len_q, len_d;
    logic [15:0]             cnt_q, cnt_d;
    logic                    any_q, any_d;
    logic                    issue;

    // Stage 1 holds the issued lane addresses, stage 2 the address register feeding the ROM.
    logic [ADDR_WIDTH-1:0]   addr1_d [LANES];
    logic [ADDR_WIDTH-1:0]   addr1_q [LANES];
    logic [ADDR_WIDTH-1:0]   addr2_q [LANES];
    logic                    v1_q;
    logic                    v2_q;

    logic [LANES*DATA_WIDTH-1:0] data_q, data_d;
    logic                        valid_q;
    logic                        busy_q, busy_d;
    logic                        done_q, done_d;
    logic [LANES-1:0]            dith2_bits;

    // Control FSM: start is only looked at in IDLE, stop only in RUN.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        inc_d   = inc_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        any_d   = any_q;
        issue   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    inc_d   = phase_inc;
                    len_d   = burst_len;
                    phase_d = '0;
                    cnt_d   = '0;
                    any_d   = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = DRAIN;
                end else begin
                    issue   = 1'b1;
                    phase_d = phase_q + PHASE_WIDTH'(LANES) * inc_q;
                    cnt_d   = cnt_q + 16'd1;
                    any_d   = 1'b1;
                    if (len_q != 16'd0 && cnt_d == len_q) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (!v1_q && !v2_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            addr1_d[k] = ADDR_WIDTH'((phase_q + PHASE_WIDTH'(k) * inc_q) >> (PHASE_WIDTH - ADDR_WIDTH));
        end
    end

`ifdef TONE_SOURCE_DITHER_EN
    logic [15:0]      lfsr_q;
    logic [LANES-1:0] dith1_q;
    logic [LANES-1:0] dith2_q;
    logic             lfsr_fb;

    assign lfsr_fb    = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
    assign dith2_bits = dith2_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr_q  <= 16'hACE1;
            dith1_q <= '0;
            dith2_q <= '0;
        end else begin
            if (issue) begin
                for (int k = 0; k < LANES; k++) begin
                    dith1_q[k] <= lfsr_q[k % 16];
                end
                lfsr_q <= {lfsr_fb, lfsr_q[15:1]};
            end
            if (v1_q) begin
                dith2_q <= dith1_q;
            end
        end
    end
`else
    assign dith2_bits = '0;
`endif

    // Done marks the last vector leaving the pipe; with nothing issued it fires on the empty drain.
    always_comb begin
        data_d = data_q;
        if (v2_q) begin
            for (int k = 0; k < LANES; k++) begin
                data_d[k*DATA_WIDTH +: DATA_WIDTH] = rom[addr2_q[k]]
                    ^ {{(DATA_WIDTH-1){1'b0}}, dith2_bits[k]};
            end
        end
        done_d = (state_q == DRAIN) && !v1_q && (v2_q || !any_q);
        busy_d = (state_q != IDLE) && !done_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            phase_q <= '0;
            inc_q   <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            any_q   <= 1'b0;
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            for (int k = 0; k < LANES; k++) begin
                addr1_q[k] <= '0;
                addr2_q[k] <= '0;
            end
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            inc_q   <= inc_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            any_q   <= any_d;
            v1_q    <= issue;
            v2_q    <= v1_q;
            if (issue) begin
                for (int k = 0; k < LANES; k++) begin
                    addr1_q[k] <= addr1_d[k];
                end
            end
            if (v1_q) begin
                for (int k = 0; k < LANES; k++) begin
                    addr2_q[k] <= addr1_q[k];
                end
            end
            data_q  <= data_d;
            valid_q <= v2_q;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign data_out  = data_q;
    assign valid     = valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign state_dbg = state_q;

endmodule
